sched_palabras: RTL
===================

Name: sched_palabras

Overview:
- Command sequencer downstream of the 4-byte word assembler in the UART front end.
- Consumes assembled 32-bit words, parses each header, and streams the payload words to one of two compute engines over valid/ready, through a small internal FIFO.
- Detects malformed, stalled and overflowing commands, reports an error code, and pulses a resync request back to the word assembler.

Parameters:
- DEPTH, 4, payload FIFO depth in words (power of two, ≥2).
- TIMEOUT, 1000, max idle cycles between payload words before abort.
- MAGIC, 8'hA5, required header byte [31:24].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- word_in  in  32  assembled word from word assembler.
- word_valid  in  1  one-cycle strobe, word_in valid; no upstream backpressure.
- out_data  out  32  payload word to engines (shared bus).
- out_valid  out  2  per-engine valid, one-hot or zero.
- out_ready  in  2  per-engine ready.
- cur_op  out  4  opcode of active command.
- busy  out  1  high in any state other than IDLE.
- cmd_done  out  1  one-cycle pulse when a command fully drains.
- err_code  out  2  0 none, 1 bad header, 2 timeout, 3 overflow/unexpected word.
- asm_clear  out  1  one-cycle pulse requesting word assembler realignment.

Behaviour:
- Reset (async, rst=1), all outputs 0: state=IDLE, FIFO empty, counters 0, err_code=0.
- Header word: [31:24]=MAGIC, [23:20]=opcode, [19:16]=dst (0 or 1 legal), [15:8] reserved/ignored, [7:0]=len (payload words, 0..255).
- IDLE:
  - word_valid with good header: latch cur_op, dst, len; clear err_code.
    - len=0: pulse cmd_done next cycle, stay IDLE.
    - else: go to PAYLOAD, timeout counter=0.
  - Bad magic or dst>1: err_code=1, go to ERROR.
- PAYLOAD:
  - Each word_valid pushes word_in into FIFO, decrements remaining, resets timeout counter.
  - Last word pushed: go to DRAIN.
  - Timeout counter reaches TIMEOUT with no word: err_code=2, go to ERROR.
  - Push with FIFO full and no pop in the same cycle: word dropped, err_code=3, go to ERROR.
  - Full with simultaneous pop: push accepted.
- DRAIN:
  - When FIFO is empty: pulse cmd_done, go to IDLE.
  - word_valid in DRAIN: err_code=3, go to ERROR.
- ERROR (exactly 1 cycle): flush FIFO, deassert out_valid, pulse asm_clear, go to IDLE.
  - err_code is sticky until the next good header.
- Output side (PAYLOAD and DRAIN):
  - out_valid[dst] = FIFO non-empty; out_data = FIFO head.
  - Pop on out_valid[dst] & out_ready[dst]; the other engine's valid stays 0.
  - out_data stable while valid & !ready.
- Latency: a word pushed into an empty FIFO is visible on out_data/out_valid the following cycle.
- Timing:
  - cmd_done asserts the cycle after the final pop is observed as empty.
  - asm_clear asserts the cycle after ERROR entry.
- Counters: remaining is 8-bit; FIFO count is clog2(DEPTH)+1 bits; timeout counter is 16-bit, saturating.
- rst mid-command: immediate return to reset state; any partial payload is discarded.

Decomposition:
- Package pkg_palabras:
  - state enum {IDLE, PAYLOAD, DRAIN, ERROR}.
  - err_code enum.
  - MAGIC default and header field bit-position constants.
  - Opcode typedef (4-bit).
- Sub-module fifo_palabras:
  - Parameterised synchronous FIFO with push/pop/flush, full/empty, count.
  - Same clk/rst convention.

Test Plan:
- Header 32'hA5_3_0_00_03, then words 11,22,33, out_ready[0]=1 → out_valid=2'b01, out_data 11,22,33 in order, cur_op=3, one cmd_done, err_code=0.
- Header 32'hA5_1_1_00_02, words AA,BB with out_ready[1]=0 for 5 cycles → out_data holds AA, out_valid=2'b10, no loss; cmd_done after release.
- Header 32'h5A_0_0_00_01 → err_code=1, asm_clear pulse, busy low within 2 cycles.
- Header with len=5, 2 words sent, then silence TIMEOUT cycles → err_code=2, FIFO flushed, asm_clear pulse, out_valid=0.
- DEPTH=4, len=6, out_ready=0, 5 words back-to-back → 5th word gives err_code=3; the next good header clears err_code.
- Header len=0 → cmd_done pulse, busy never high; rst asserted mid-PAYLOAD → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pkg_palabras.sv
// Shared types and header field layout for the word-stream command sequencer.
package pkg_palabras;

  typedef enum logic [1:0] {StIdle, StPayload, StDrain, StError} state_e;

  typedef enum logic [1:0] {ErrNone, ErrHeader, ErrTimeout, ErrOverflow} err_e;

  typedef logic [3:0] opcode_t;

  localparam logic [7:0] MagicDefault = 8'hA5;

  localparam int unsigned MagicLsb = 24;
  localparam int unsigned OpLsb    = 20;
  localparam int unsigned DstLsb   = 16;
  localparam int unsigned LenLsb   = 0;

  function automatic logic hdr_ok(input logic [31:0] w, input logic [7:0] magic);
    return (w[MagicLsb +: 8] == magic) && (w[DstLsb +: 4] <= 4'd1);
  endfunction

endpackage

// File: rtl/fifo_palabras.sv
// Synchronous word FIFO with flush; a push while full is accepted only alongside a pop.
module fifo_palabras #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW + 1)'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/sched_palabras.sv
// Parses command headers from assembled words and streams payload to one of two engines.
module sched_palabras
  import pkg_palabras::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter logic [7:0]  MAGIC   = MagicDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic [31:0] out_data,
  output logic [1:0]  out_valid,
  input  logic [1:0]  out_ready,
  output logic [3:0]  cur_op,
  output logic        busy,
  output logic        cmd_done,
  output logic [1:0]  err_code,
  output logic        asm_clear
);

  state_e      state_q;
  opcode_t     op_q;
  logic        dst_q;
  logic [7:0]  rem_q;
  logic [15:0] tmo_q;
  err_e        err_q;
  logic        done_q, clr_q;

  logic        active, push, pop, flush;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;

  assign active = (state_q == StPayload) || (state_q == StDrain);
  assign pop    = active & ~fifo_empty & out_ready[dst_q];
  assign push   = (state_q == StPayload) & word_valid & (~fifo_full | pop);
  assign flush  = (state_q == StError);

  fifo_palabras #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (word_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    out_valid = 2'b00;
    if (active && !fifo_empty) out_valid = dst_q ? 2'b10 : 2'b01;
  end

  assign out_data  = (|out_valid) ? fifo_head : '0;
  assign cur_op    = op_q;
  assign busy      = (state_q != StIdle);
  assign cmd_done  = done_q;
  assign err_code  = err_q;
  assign asm_clear = clr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      dst_q   <= 1'b0;
      rem_q   <= '0;
      tmo_q   <= '0;
      err_q   <= ErrNone;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (word_valid) begin
            if (hdr_ok(word_in, MAGIC)) begin
              op_q  <= word_in[OpLsb +: 4];
              dst_q <= word_in[DstLsb];
              rem_q <= word_in[LenLsb +: 8];
              err_q <= ErrNone;
              tmo_q <= '0;
              if (word_in[LenLsb +: 8] == 8'd0) done_q <= 1'b1;
              else state_q <= StPayload;
            end else begin
              err_q   <= ErrHeader;
              state_q <= StError;
            end
          end
        end
        StPayload: begin
          if (word_valid) begin
            if (fifo_full && !pop) begin
              err_q   <= ErrOverflow;
              state_q <= StError;
            end else begin
              tmo_q <= '0;
              rem_q <= rem_q - 8'd1;
              if (rem_q == 8'd1) state_q <= StDrain;
            end
          end else if (tmo_q >= 16'(TIMEOUT)) begin
            err_q   <= ErrTimeout;
            state_q <= StError;
          end else if (tmo_q != 16'hFFFF) begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        StDrain: begin
          if (word_valid) begin
            err_q   <= ErrOverflow;
            state_q <= StError;
          end else if (fifo_empty) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        StError: begin
          clr_q   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
